// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Build option SERIAL_SUB_SAT_EN is consumed by serial_subtractor.sv.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

  // Bit counter only has to reach WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set on local underflow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b over WIDTH cycles.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero on unsigned underflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
  output sub_state_t       state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  // Handshake: start is sampled only in IDLE or DONE; a rising edge with
  // start=1 in those states captures a/b. done pulses for one cycle and
  // diff/borrow_out stay valid until the next accepted start.
  sub_state_t       state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             done_q;

  logic             bit_d;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_d;
  logic             last_bit;

  full_subtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (borrow_d)
  );

  assign res_d    = {bit_d, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    diff_d = res_d;
`ifdef SERIAL_SUB_SAT_EN
    if (borrow_d) diff_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_q    <= res_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          // Final bit: publish result and pulse done in the same edge.
          if (last_bit) begin
            diff_q       <= diff_d;
            borrow_out_q <= borrow_d;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8), directed and random.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;
  sub_state_t   state_dbg;

  int n_cmp;
  int n_fail;
  int cyc;
  int last_done_cyc;
  logic [W-1:0] last_diff;
  logic         last_bout;
  logic [W:0]   exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on integers.
  function automatic logic [W:0] model(input int av, input int bv);
    int r;
    logic bo;
    bo = (av < bv);
    r  = (av - bv + (1 << W)) % (1 << W);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) r = 0;
`endif
    return {bo, r[W-1:0]};
  endfunction

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    exp_q.push_back(model(int'(av), int'(bv)));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Waits for done after an accepting edge; inject pokes start mid-RUN.
  task automatic collect(input bit inject);
    int   edges;
    bit   seen;
    logic [W:0] e;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        check("busy_run", busy, 1'b1);
        check("diff_hold", diff, last_diff);
        check("bout_hold", borrow_out, last_bout);
      end
      if (inject) begin
        start = (edges == 3);
        a = 8'd1;
        b = 8'd9;
      end
    end
    check("done_seen", seen, 1'b1);
    check("latency", edges, W);
    check("busy_at_done", busy, 1'b0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("diff", diff, e[W-1:0]);
    check("borrow_out", borrow_out, e[W]);
    if (last_done_cyc >= 0) check("done_gap", cyc - last_done_cyc, W + 1);
    last_done_cyc = -1;
    last_diff = e[W-1:0];
    last_bout = e[W];
    @(posedge clk);
    @(negedge clk);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    last_done_cyc = -1;
    last_diff = '0;
    last_bout = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    repeat (2) @(negedge clk);
    check("rst_diff", diff, 0);
    check("rst_bout", borrow_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // directed
    issue(8'd5, 8'd3);     collect(1'b0);
    issue(8'd3, 8'd5);     collect(1'b0);
    issue(8'd0, 8'd0);     collect(1'b0);
    issue(8'd255, 8'd255); collect(1'b0);
    issue(8'd0, 8'd1);     collect(1'b0);
    issue(8'd255, 8'd0);   collect(1'b0);

    // start during RUN must be ignored
    issue(8'd10, 8'd4);    collect(1'b1);
    start = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("no_extra_done", done, 1'b0);
    end

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    a = 8'd100;
    b = 8'd1;
    exp_q.push_back(model(100, 1));
    @(posedge clk);
    #1;
    a = 8'd1;
    b = 8'd2;
    exp_q.push_back(model(1, 2));
    collect(1'b0);
    start = 1'b0;
    last_done_cyc = cyc - 1;
    collect(1'b0);

    // async reset mid-operation
    issue(8'd50, 8'd20);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_diff", diff, 0);
    check("arst_bout", borrow_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    void'(exp_q.pop_back());
    last_diff = '0;
    last_bout = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      check("arst_no_done", done, 1'b0);
    end
    issue(8'd7, 8'd2);     collect(1'b0);

    // random
    repeat (25) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      collect(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
